seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side counterpart of the hex-to-7-segment decoder. It snoops a multiplexed 4-digit seven-segment drive bus (segment lines plus one-hot digit select), samples each digit once the select has settled, and maps each segment pattern back to its hex nibble. It commits a 16-bit value only after a configurable number of identical, error-free scan frames. It sits in test and loopback paths to check display drivers and to read values back from legacy display outputs.

## Interface
- SETTLE_CYC, 4: consecutive cycles a digit select must be held before its segments are sampled; legal range 1..255.
- STABLE_FRAMES, 2: consecutive identical good frames required before a commit; legal range 1..15.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seg  in  7  segment lines, active-high, seg[6]=a … seg[0]=g.
- dig_sel  in  4  digit select, active-high one-hot; dig_sel[k] selects nibble k.
- value  out  16  committed hex value; nibble k = value[4k+3:4k].
- valid  out  1  level; high once the first commit has occurred.
- upd_stb  out  1  one-cycle pulse on each commit whose value differs from the previous one, including the first commit.
- err_stb  out  1  one-cycle pulse when an illegal pattern is sampled.

## Operation
- Pattern map (seg[6:0] -> nibble): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1110011->9, 1110111->A, 0011111->b, 1001110->C, 0111101->d, 1001111->E, 1000111->F. Any other pattern is illegal.
- Settle counter, 8 bits: cleared whenever dig_sel changes or is not one-hot (zero or more than one bit set); increments while a legal dig_sel is held; saturates after the sample.
- Sample: exactly one per dwell, on the edge where the same legal dig_sel has been seen for SETTLE_CYC consecutive cycles. The decoded nibble is written to the frame buffer slot k and bit k of the 4-bit seen-mask is set.
  - Illegal sample: sets the frame-bad flag and pulses err_stb.
  - Resampling a slot already in the mask overwrites it; the mask is unchanged.
  - Digit order does not matter.
- Frame complete: mask == 4'b1111. In the following cycle:
  - Bad frame: match count cleared; frame discarded.
  - Good frame equal to the previous good frame: match count increments, saturating at STABLE_FRAMES.
  - Good frame differing from the previous good frame: match count set to 1.
  - Frame stored as the previous good frame.
  - Mask and bad flag cleared.
- Commit: when the match count reaches STABLE_FRAMES, value <= frame and valid <= 1. upd_stb pulses if the value changed. Further identical frames re-commit silently.
- Non-one-hot dig_sel (blanking): no sample; the frame in progress is kept.

## Timing
- Reset values: value=16'h0000, valid=0, upd_stb=0, err_stb=0; settle counter, mask, match count and bad flag cleared; previous-frame register 0.
- Sample latency: SETTLE_CYC cycles after dig_sel becomes stable and legal.
- err_stb is asserted in the cycle after the sampling edge.
- Commit latency: value, valid and upd_stb update on the second edge after the edge that completes the frame (one evaluation cycle).
- Reset mid-frame discards all partial state immediately; no strobe is emitted.
- Sample and frame evaluation in the same cycle: evaluation uses the completed frame. The new sample lands in a cleared mask.

## Configuration
- SEGDEC_ERRCNT_EN defined:
  - Adds output err_count (8 bits, reset 0), incremented on each err_stb and saturating at 255.
  - Adds input err_clr (1 bit), a synchronous clear; clear takes priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is built.

## Test plan
- Scan 1,2,3,4 on dig_sel[0..3] with SETTLE_CYC=4 and a dwell of 6 cycles, for 2 frames -> value=16'h4321, valid=1, one upd_stb; a third identical frame produces no upd_stb.
- Change one digit to 0011111 for 2 frames -> value=16'h43B1 and upd_stb pulses.
- Inject pattern 0000001 on digit 2 -> err_stb pulses once, the frame is discarded, value is held, and the match count restarts (commit needs 2 further good frames).
- Dwell of 3 cycles (< SETTLE_CYC) -> no sample, valid stays 0. Insert dig_sel=4'b0000 or 4'b0011 gaps between digits -> commit timing unchanged apart from the gap cycles.
- Assert rst mid-frame after 2 digits -> all outputs at reset values; the next 2 full frames commit normally.
- With SEGDEC_ERRCNT_EN: inject 300 illegal samples -> err_count=255. Pulse err_clr together with an error -> err_count=0.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: snoops a multiplexed 4-digit seven-segment drive bus,
// samples each digit once its select has settled, decodes the pattern back
// to a hex nibble and commits a 16-bit value after STABLE_FRAMES identical
// error-free frames.
// Optional feature macro: SEGDEC_ERRCNT_EN adds err_count / err_clr, a
// saturating count of illegal samples with a synchronous clear.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYC    = 4,  // 1..255
  parameter int unsigned STABLE_FRAMES = 2   // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
`ifdef SEGDEC_ERRCNT_EN
  input  logic        err_clr,
  output logic [7:0]  err_count,
`endif
  output logic [15:0] value,
  output logic        valid,
  output logic        upd_stb,
  output logic        err_stb
);

  localparam logic [8:0] SETTLE_W = 9'(SETTLE_CYC);
  localparam logic [3:0] STABLE_W = 4'(STABLE_FRAMES);

  logic [3:0]       sel_q;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0][3:0]  buf_q, buf_d;
  logic [3:0]       mask_q, mask_d;
  logic             bad_q, bad_d;
  logic [3:0]       match_q, match_d;
  logic [15:0]      prev_q, prev_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [15:0]      value_q;
  logic             valid_q, upd_q;

  logic             sel_onehot;
  logic [8:0]       run_w;
  logic             sample_w;
  logic [1:0]       slot_w;
  logic [3:0]       nib_w;
  logic             nib_ok_w;
  logic             frame_done;

  // Segment pattern back to nibble; anything off the table is illegal.
  always_comb begin
    nib_ok_w = 1'b1;
    nib_w    = 4'h0;
    case (seg)
      7'b1111110: nib_w = 4'h0;
      7'b0110000: nib_w = 4'h1;
      7'b1101101: nib_w = 4'h2;
      7'b1111001: nib_w = 4'h3;
      7'b0110011: nib_w = 4'h4;
      7'b1011011: nib_w = 4'h5;
      7'b1011111: nib_w = 4'h6;
      7'b1110000: nib_w = 4'h7;
      7'b1111111: nib_w = 4'h8;
      7'b1110011: nib_w = 4'h9;
      7'b1110111: nib_w = 4'hA;
      7'b0011111: nib_w = 4'hB;
      7'b1001110: nib_w = 4'hC;
      7'b0111101: nib_w = 4'hD;
      7'b1001111: nib_w = 4'hE;
      7'b1000111: nib_w = 4'hF;
      default:    nib_ok_w = 1'b0;
    endcase
  end

  // Dwell tracking: run_w is the number of consecutive cycles, including this
  // one, that the current legal select has been seen. One sample per dwell,
  // taken when the run hits SETTLE_CYC; the counter then parks at SETTLE_CYC.
  always_comb begin
    sel_onehot = (dig_sel != 4'b0000) && ((dig_sel & (dig_sel - 4'b0001)) == 4'b0000);
    run_w      = (dig_sel == sel_q) ? ({1'b0, cnt_q} + 9'd1) : 9'd1;
    sample_w   = sel_onehot && (run_w == SETTLE_W);
    if (!sel_onehot)
      cnt_d = 8'd0;
    else if (run_w >= SETTLE_W)
      cnt_d = SETTLE_W[7:0];
    else
      cnt_d = run_w[7:0];
    slot_w = 2'd0;
    case (dig_sel)
      4'b0010: slot_w = 2'd1;
      4'b0100: slot_w = 2'd2;
      4'b1000: slot_w = 2'd3;
      default: slot_w = 2'd0;
    endcase
  end

  // Frame assembly and evaluation. Evaluation sees the completed frame from
  // the registers, so a sample landing in the same cycle goes into the
  // freshly cleared mask without disturbing it.
  always_comb begin
    buf_d      = buf_q;
    mask_d     = mask_q;
    bad_d      = bad_q;
    match_d    = match_q;
    prev_d     = prev_q;
    pend_d     = 1'b0;
    err_d      = 1'b0;
    frame_done = (mask_q == 4'b1111);
    if (frame_done) begin
      mask_d = 4'b0000;
      bad_d  = 1'b0;
      if (bad_q) begin
        match_d = 4'd0;
      end else begin
        if (buf_q == prev_q)
          match_d = (match_q >= STABLE_W) ? STABLE_W : (match_q + 4'd1);
        else
          match_d = 4'd1;
        prev_d = buf_q;
        pend_d = (match_d == STABLE_W);
      end
    end
    if (sample_w) begin
      buf_d[slot_w]  = nib_w;
      mask_d[slot_w] = 1'b1;
      if (!nib_ok_w) begin
        bad_d = 1'b1;
        err_d = 1'b1;
      end
    end
  end

  // State registers, plus the commit stage one cycle behind evaluation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 4'b0000;
      cnt_q   <= 8'd0;
      buf_q   <= '0;
      mask_q  <= 4'b0000;
      bad_q   <= 1'b0;
      match_q <= 4'd0;
      prev_q  <= 16'h0000;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      value_q <= 16'h0000;
      valid_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      sel_q   <= dig_sel;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      mask_q  <= mask_d;
      bad_q   <= bad_d;
      match_q <= match_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      upd_q   <= 1'b0;
      if (pend_q) begin
        value_q <= prev_q;
        valid_q <= 1'b1;
        upd_q   <= !valid_q || (prev_q != value_q);
      end
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign upd_stb = upd_q;
  assign err_stb = err_q;

`ifdef SEGDEC_ERRCNT_EN
  logic [7:0] errcnt_q;

  // Saturating illegal-sample counter; clear wins over a coincident error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      errcnt_q <= 8'd0;
    else if (err_clr)
      errcnt_q <= 8'd0;
    else if (err_q && (errcnt_q != 8'hFF))
      errcnt_q <= errcnt_q + 8'd1;
  end

  assign err_count = errcnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Testbench for seg_scan_decoder (SETTLE_CYC=4, STABLE_FRAMES=2).
module tb_seg_scan_decoder;

  localparam logic [6:0] P0 = 7'b1111110, P1 = 7'b0110000, P2 = 7'b1101101,
                         P3 = 7'b1111001, P4 = 7'b0110011, P5 = 7'b1011011,
                         P6 = 7'b1011111, P7 = 7'b1110000, P8 = 7'b1111111,
                         P9 = 7'b1110011, PA = 7'b1110111, PB = 7'b0011111,
                         PC = 7'b1001110, PD = 7'b0111101, PE = 7'b1001111,
                         PF = 7'b1000111, PX = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'd0;
  logic [3:0]  dig_sel = 4'd0;
  logic [15:0] value;
  logic        valid, upd_stb, err_stb;
`ifdef SEGDEC_ERRCNT_EN
  logic        err_clr = 1'b0;
  logic [7:0]  err_count;
`endif

  int total = 0;
  int bad = 0;
  int upd_seen = 0;
  int err_seen = 0;

  typedef struct {
    logic [3:0][6:0] segs;
    int              frames;
    int              dwell;
    logic [15:0]     exp_value;
    logic            exp_valid;
    int              exp_upd;
    int              exp_err;
  } vec_t;

  vec_t vecs [9];

  seg_scan_decoder #(.SETTLE_CYC(4), .STABLE_FRAMES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_sel   (dig_sel),
`ifdef SEGDEC_ERRCNT_EN
    .err_clr   (err_clr),
    .err_count (err_count),
`endif
    .value     (value),
    .valid     (valid),
    .upd_stb   (upd_stb),
    .err_stb   (err_stb)
  );

  // clock
  always #5 clk = ~clk;

  // strobe counters, sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (upd_stb === 1'b1) upd_seen++;
    if (err_stb === 1'b1) err_seen++;
  end

  function automatic vec_t mk(input logic [3:0][6:0] s, input int fr, input int dw,
                              input logic [15:0] v, input logic vl, input int u, input int e);
    vec_t r;
    r.segs = s; r.frames = fr; r.dwell = dw;
    r.exp_value = v; r.exp_valid = vl; r.exp_upd = u; r.exp_err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // all drivers start and end on a falling edge
  task automatic drive(input int k, input logic [6:0] p, input int dwell);
    dig_sel = 4'(1 << k);
    seg = p;
    repeat (dwell) @(negedge clk);
  endtask

  task automatic drive_raw(input logic [3:0] sel, input int n);
    dig_sel = sel;
    seg = 7'd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [3:0][6:0] s, input int dwell);
    for (int k = 0; k < 4; k++) drive(k, s[k], dwell);
  endtask

  // drive one digit for 8 cycles and report at which cycle each strobe was seen
  task automatic timed_digit(input int k, input logic [6:0] p,
                             output int upd_at, output int upd_n,
                             output int err_at, output int err_n);
    upd_at = 0; upd_n = 0; err_at = 0; err_n = 0;
    dig_sel = 4'(1 << k);
    seg = p;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (upd_stb) begin upd_at = i; upd_n++; end
      if (err_stb) begin err_at = i; err_n++; end
    end
  endtask

  initial begin
    int u0, e0, ua, un, ea, en;

    vecs[0] = mk({P4, P3, P2, P1}, 2, 6, 16'h4321, 1'b1, 1, 0);
    vecs[1] = mk({P4, P3, P2, P1}, 1, 6, 16'h4321, 1'b1, 0, 0);
    vecs[2] = mk({P4, P3, PB, P1}, 2, 6, 16'h43B1, 1'b1, 1, 0);
    vecs[3] = mk({P4, PX, PB, P1}, 1, 6, 16'h43B1, 1'b1, 0, 1);
    vecs[4] = mk({P8, P7, P6, P5}, 1, 6, 16'h43B1, 1'b1, 0, 0);
    vecs[5] = mk({P8, P7, P6, P5}, 1, 6, 16'h8765, 1'b1, 1, 0);
    vecs[6] = mk({PD, PC, PA, P9}, 2, 3, 16'h8765, 1'b1, 0, 0);
    vecs[7] = mk({P0, P0, PF, PE}, 2, 4, 16'h00FE, 1'b1, 1, 0);
    vecs[8] = mk({PD, PC, PA, P9}, 2, 6, 16'hDCA9, 1'b1, 1, 0);

    // reset
    repeat (3) @(negedge clk);
    chk("reset_value", 32'(value), 32'h0000);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_upd", 32'(upd_stb), 32'h0);
    chk("reset_err", 32'(err_stb), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // table-driven frames
    for (int v = 0; v < 9; v++) begin
      u0 = upd_seen;
      e0 = err_seen;
      for (int f = 0; f < vecs[v].frames; f++) scan_frame(vecs[v].segs, vecs[v].dwell);
      drive_raw(4'b0000, 4);
      chk($sformatf("vec%0d_value", v), 32'(value), 32'(vecs[v].exp_value));
      chk($sformatf("vec%0d_valid", v), 32'(valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_upd", v), 32'(upd_seen - u0), 32'(vecs[v].exp_upd));
      chk($sformatf("vec%0d_err", v), 32'(err_seen - e0), 32'(vecs[v].exp_err));
    end

    // gaps, out-of-order digits and an overwritten slot; exact commit timing
    u0 = upd_seen;
    drive(0, P5, 6);
    drive_raw(4'b0000, 2);
    drive(0, P1, 6);
    drive_raw(4'b0011, 3);
    drive(3, P4, 6);
    drive(2, P3, 6);
    drive_raw(4'b0000, 2);
    drive(1, P2, 6);
    chk("gap_frame1_no_upd", 32'(upd_seen - u0), 32'd0);
    drive(2, P3, 6);
    drive_raw(4'b0011, 1);
    drive(0, P1, 6);
    drive(3, P4, 6);
    drive_raw(4'b0000, 3);
    timed_digit(1, P2, ua, un, ea, en);
    chk("gap_upd_cycle", 32'(ua), 32'd6);
    chk("gap_upd_count", 32'(un), 32'd1);
    chk("gap_value", 32'(value), 32'h4321);

    // illegal sample: err_stb one cycle after the sampling edge
    timed_digit(2, PX, ua, un, ea, en);
    chk("err_cycle", 32'(ea), 32'd4);
    chk("err_count_pulses", 32'(en), 32'd1);
    chk("err_value_held", 32'(value), 32'h4321);

    // reset mid-frame after two digits
    drive(0, P1, 6);
    drive(1, P2, 6);
    rst = 1'b1;
    #1;
    chk("midrst_value", 32'(value), 32'h0000);
    chk("midrst_valid", 32'(valid), 32'h0);
    chk("midrst_upd", 32'(upd_stb), 32'h0);
    chk("midrst_err", 32'(err_stb), 32'h0);
`ifdef SEGDEC_ERRCNT_EN
    chk("midrst_errcnt", 32'(err_count), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    dig_sel = 4'b0000;
    @(negedge clk);
    // short dwells never sample
    scan_frame({P4, P3, P2, P1}, 3);
    scan_frame({P4, P3, P2, P1}, 3);
    drive_raw(4'b0000, 4);
    chk("short_dwell_valid", 32'(valid), 32'h0);
    u0 = upd_seen;
    scan_frame({P4, P3, P2, P1}, 6);
    drive_raw(4'b0000, 4);
    chk("post_rst_one_frame_valid", 32'(valid), 32'h0);
    scan_frame({P4, P3, P2, P1}, 6);
    drive_raw(4'b0000, 4);
    chk("post_rst_value", 32'(value), 32'h4321);
    chk("post_rst_valid", 32'(valid), 32'h1);
    chk("post_rst_upd", 32'(upd_seen - u0), 32'd1);

`ifdef SEGDEC_ERRCNT_EN
    // error counter saturation and clear-over-increment
    chk("errcnt_start", 32'(err_count), 32'd0);
    for (int i = 0; i < 300; i++) drive(i % 2, PX, 4);
    drive_raw(4'b0000, 3);
    chk("errcnt_sat", 32'(err_count), 32'd255);
    drive(0, PX, 4);
    chk("errclr_err_stb", 32'(err_stb), 32'h1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("errclr_count", 32'(err_count), 32'd0);
    drive_raw(4'b0000, 3);
    chk("errclr_hold", 32'(err_count), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
